bcd_seq_conv: RTL and testbench

Parametrised sequential binary-to-BCD converter for the calculator datapath. It uses shift-and-add-3 (double dabble), one input bit per clock. It converts a W-bit binary result into D packed BCD digits for the seven-segment display path, without instantiating dividers. It adds a start/ready handshake, a busy flag, overflow detection when D digits are too few, and a leading-zero blanking mask.

---
 rtl/bcd_seq_conv.sv | 163 ++++++++++++++++
 tb/tb_bcd_seq_conv.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BCD_SIGNED_EN to treat `in` as two's complement and report its sign on `neg`.
module bcd_seq_conv #(
    parameter int W = 16,
    parameter int D = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in,
    input  logic           strt,
    output logic           busy,
    output logic           rdy,
    output logic [4*D-1:0] bcd,
    output logic [D-1:0]   blank,
    output logic           ovf,
    output logic           neg
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_r;
    logic [W-1:0]   shreg_r;
    logic [4*D-1:0] scratch_r;
    logic [CW-1:0]  cnt_r;
    logic           ovf_acc_r;
    logic           busy_r;
    logic           rdy_r;
    logic           ovf_r;
    logic [4*D-1:0] bcd_r;
    logic [D-1:0]   blank_r;

    logic [4*D-1:0] corr_s;
    logic [4*D-1:0] next_scratch_s;
    logic [W-1:0]   next_shreg_s;
    logic [W-1:0]   load_val_s;
    logic           ovf_bit_s;
    logic           last_s;

    // blank[i] is set when digit i and every digit above it are zero; the ones digit always shows.
    function automatic logic [D-1:0] blank_mask(input logic [4*D-1:0] digits);
        logic [D-1:0] m;
        logic         nz;
        m  = '0;
        nz = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            nz   = nz | (digits[4*i +: 4] != 4'd0);
            m[i] = ~nz;
        end
        m[0] = 1'b0;
        return m;
    endfunction

    // Per-digit add-3 correction applied ahead of every shift.
    for (genvar g = 0; g < D; g++) begin : g_digit
        assign corr_s[4*g +: 4] = (scratch_r[4*g +: 4] >= 4'd5) ? (scratch_r[4*g +: 4] + 4'd3)
                                                                : scratch_r[4*g +: 4];
    end

    // One double-dabble step; a corrected top digit of 8 or more loses its MSB off the end.
    always_comb begin
        next_scratch_s = {corr_s[4*D-2:0], shreg_r[W-1]};
        next_shreg_s   = {shreg_r[W-2:0], 1'b0};
        ovf_bit_s      = corr_s[4*D-1];
        last_s         = (cnt_r == CW'(1));
    end

`ifdef BCD_SIGNED_EN
    logic sign_r;
    logic neg_r;
    logic load_sign_s;

    // Magnitude of a two's complement operand; the most negative value maps to 2^(W-1).
    always_comb begin
        load_sign_s = in[W-1];
        if (in[W-1]) begin
            load_val_s = ~in + {{(W-1){1'b0}}, 1'b1};
        end else begin
            load_val_s = in;
        end
    end

    // Sign captured at acceptance and presented alongside the digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (strt && (state_r != SHIFT)) begin
            sign_r <= load_sign_s;
        end else if ((state_r == SHIFT) && last_s) begin
            neg_r <= sign_r;
        end
    end

    assign neg = neg_r;
`else
    assign load_val_s = in;
    assign neg        = 1'b0;
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shreg_r   <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            ovf_acc_r <= 1'b0;
            busy_r    <= 1'b0;
            rdy_r     <= 1'b0;
            ovf_r     <= 1'b0;
            bcd_r     <= '0;
            blank_r   <= blank_mask('0);
        end else begin
            rdy_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (strt) begin
                        state_r   <= SHIFT;
                        shreg_r   <= load_val_s;
                        scratch_r <= '0;
                        ovf_acc_r <= 1'b0;
                        cnt_r     <= CW'(W);
                        busy_r    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    scratch_r <= next_scratch_s;
                    shreg_r   <= next_shreg_s;
                    ovf_acc_r <= ovf_acc_r | ovf_bit_s;
                    cnt_r     <= cnt_r - CW'(1);
                    if (last_s) begin
                        // Results land together with rdy, one cycle in DONE.
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        rdy_r   <= 1'b1;
                        bcd_r   <= next_scratch_s;
                        blank_r <= blank_mask(next_scratch_s);
                        ovf_r   <= ovf_acc_r | ovf_bit_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign rdy   = rdy_r;
    assign bcd   = bcd_r;
    assign blank = blank_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: two instances (5 and 4 digits) share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_bcd_seq_conv;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         strt;
    logic [W-1:0] in;

    logic        b5_busy, b5_rdy, b5_ovf, b5_neg;
    logic [19:0] b5_bcd;
    logic [4:0]  b5_blank;
    logic        b4_busy, b4_rdy, b4_ovf, b4_neg;
    logic [15:0] b4_bcd;
    logic [3:0]  b4_blank;

    int errors = 0;
    int checks = 0;

    bcd_seq_conv #(.W(W), .D(5)) u_d5 (
        .clk(clk), .rst(rst), .in(in), .strt(strt),
        .busy(b5_busy), .rdy(b5_rdy), .bcd(b5_bcd), .blank(b5_blank), .ovf(b5_ovf), .neg(b5_neg)
    );

    bcd_seq_conv #(.W(W), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .in(in), .strt(strt),
        .busy(b4_busy), .rdy(b4_rdy), .bcd(b4_bcd), .blank(b4_blank), .ovf(b4_ovf), .neg(b4_neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [39:0] exp_bcd(input longint m, input int d);
        logic [39:0] r;
        longint      v;
        r = '0;
        v = m % pow10(d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [9:0] exp_blank(input longint m, input int d);
        logic [9:0] r;
        r = '0;
        for (int i = 1; i < d; i++) r[i] = ((m % pow10(d)) < pow10(i));
        return r;
    endfunction

    function automatic longint mag_of(input logic [W-1:0] v);
`ifdef BCD_SIGNED_EN
        if (v[W-1]) return (longint'(1) << W) - longint'(v);
        else return longint'(v);
`else
        return longint'(v);
`endif
    endfunction

    function automatic bit sign_of(input logic [W-1:0] v);
`ifdef BCD_SIGNED_EN
        return v[W-1];
`else
        return (v == '0) && (v != '0);
`endif
    endfunction

    // Reference model: acceptance when not converting, result W cycles after acceptance.
    int          m_left = 0;
    bit          m_busy = 1'b0;
    bit          m_rdy = 1'b0;
    longint      m_mag = 0;
    bit          m_neg = 1'b0;
    logic [39:0] e5_bcd = '0, e4_bcd = '0;
    logic [9:0]  e5_blank = 10'b0000011110, e4_blank = 10'b0000001110;
    bit          e5_ovf = 1'b0, e4_ovf = 1'b0, e_neg = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_rdy    <= 1'b0;
            m_left   <= 0;
            e5_bcd   <= '0;
            e4_bcd   <= '0;
            e5_blank <= exp_blank(0, 5);
            e4_blank <= exp_blank(0, 4);
            e5_ovf   <= 1'b0;
            e4_ovf   <= 1'b0;
            e_neg    <= 1'b0;
        end else begin
            m_rdy <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    m_rdy    <= 1'b1;
                    e5_bcd   <= exp_bcd(m_mag, 5);
                    e4_bcd   <= exp_bcd(m_mag, 4);
                    e5_blank <= exp_blank(m_mag, 5);
                    e4_blank <= exp_blank(m_mag, 4);
                    e5_ovf   <= (m_mag >= pow10(5));
                    e4_ovf   <= (m_mag >= pow10(4));
                    e_neg    <= m_neg;
                end
            end else if (strt) begin
                m_busy <= 1'b1;
                m_left <= W;
                m_mag  <= mag_of(in);
                m_neg  <= sign_of(in);
            end
        end
    end

    // Compare process: every output of both instances, every cycle, away from the edge.
    always @(posedge clk) begin
        #1;
        check("d5_busy", b5_busy, m_busy);
        check("d5_rdy", b5_rdy, m_rdy);
        check("d5_bcd", b5_bcd, e5_bcd);
        check("d5_blank", b5_blank, e5_blank);
        check("d5_ovf", b5_ovf, e5_ovf);
        check("d5_neg", b5_neg, e_neg);
        check("d4_busy", b4_busy, m_busy);
        check("d4_rdy", b4_rdy, m_rdy);
        check("d4_bcd", b4_bcd, e4_bcd);
        check("d4_blank", b4_blank, e4_blank);
        check("d4_ovf", b4_ovf, e4_ovf);
        check("d4_neg", b4_neg, e_neg);
    end

    task automatic start_conv(input logic [W-1:0] v);
        @(negedge clk);
        in   = v;
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
    endtask

    // n is the cycle number of the current cycle relative to the acceptance edge.
    task automatic wait_rdy(input int n0, output int n);
        n = n0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (b5_rdy) return;
        end
        check("rdy_timeout", 64'd0, 64'd1);
        n = -1;
    endtask

    task automatic conv_expect(input string tag, input logic [W-1:0] v,
                               input logic [19:0] bcd5, input logic [4:0] blank5, input logic ovf5,
                               input logic [15:0] bcd4, input logic ovf4, input logic neg_e);
        int n;
        start_conv(v);
        wait_rdy(1, n);
        check({tag, "_latency"}, n, 17);
        check({tag, "_bcd5"}, b5_bcd, bcd5);
        check({tag, "_blank5"}, b5_blank, blank5);
        check({tag, "_ovf5"}, b5_ovf, ovf5);
        check({tag, "_bcd4"}, b4_bcd, bcd4);
        check({tag, "_ovf4"}, b4_ovf, ovf4);
        check({tag, "_neg"}, b5_neg, neg_e);
    endtask

    logic [W-1:0] bnd [8] = '{16'd9999, 16'd10000, 16'd65535, 16'd0,
                              16'd32767, 16'd32768, 16'd99, 16'd1000};

    initial begin
        int n;
        int rdy_cnt;
        int rdy_at [2];
        logic [19:0] rdy_val [2];

        rst  = 1'b1;
        strt = 1'b0;
        in   = '0;

        check("model_bcd_9999", exp_bcd(9999, 5), 40'h09999);
        check("model_bcd_12345_d4", exp_bcd(12345, 4), 40'h2345);
        check("model_blank_42", exp_blank(42, 5), 10'b0000011100);

        repeat (3) @(negedge clk);
        check("reset_blank5", b5_blank, 5'b11110);
        check("reset_blank4", b4_blank, 4'b1110);
        check("reset_busy", b5_busy, 1'b0);
        rst = 1'b0;

        conv_expect("c9999", 16'd9999, 20'h09999, 5'b10000, 1'b0, 16'h9999, 1'b0, 1'b0);
`ifdef BCD_SIGNED_EN
        conv_expect("cm1", 16'hFFFF, 20'h00001, 5'b11110, 1'b0, 16'h0001, 1'b0, 1'b1);
        conv_expect("cm1234", 16'hFB2E, 20'h01234, 5'b10000, 1'b0, 16'h1234, 1'b0, 1'b1);
        conv_expect("cm32768", 16'h8000, 20'h32768, 5'b00000, 1'b0, 16'h2768, 1'b1, 1'b1);
`else
        conv_expect("c65535", 16'd65535, 20'h65535, 5'b00000, 1'b0, 16'h5535, 1'b1, 1'b0);
`endif
        conv_expect("c0", 16'd0, 20'h00000, 5'b11110, 1'b0, 16'h0000, 1'b0, 1'b0);
        conv_expect("c12345", 16'd12345, 20'h12345, 5'b00000, 1'b0, 16'h2345, 1'b1, 1'b0);
        conv_expect("c42", 16'd42, 20'h00042, 5'b11100, 1'b0, 16'h0042, 1'b0, 1'b0);

        // strt held for 40 cycles; the operand changes while the first conversion is busy.
        @(negedge clk);
        in      = 16'd100;
        strt    = 1'b1;
        rdy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (b5_rdy) begin
                if (rdy_cnt < 2) begin
                    rdy_at[rdy_cnt]  = c;
                    rdy_val[rdy_cnt] = b5_bcd;
                end
                rdy_cnt++;
            end
            @(negedge clk);
            if (c == 1) in = 16'd200;
            if (c == 40) strt = 1'b0;
        end
        check("b2b_rdy_count", rdy_cnt, 2);
        check("b2b_rdy0_cycle", rdy_at[0], 17);
        check("b2b_rdy0_val", rdy_val[0], 20'h00100);
        check("b2b_rdy1_cycle", rdy_at[1], 34);
        check("b2b_rdy1_val", rdy_val[1], 20'h00200);
        wait_rdy(0, n);

        // strt pulse inside busy is ignored.
        start_conv(16'd321);
        repeat (3) @(negedge clk);
        in   = 16'd999;
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        wait_rdy(5, n);
        check("ign_latency", n, 17);
        check("ign_bcd", b5_bcd, 20'h00321);

        // Reset in the middle of a conversion of 500.
        start_conv(16'd500);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", b5_busy, 1'b0);
        check("abort_bcd", b5_bcd, 20'h00000);
        check("abort_blank", b5_blank, 5'b11110);
        rdy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (b5_rdy) rdy_cnt++;
        end
        check("abort_no_rdy", rdy_cnt, 0);
        conv_expect("c7", 16'd7, 20'h00007, 5'b11110, 1'b0, 16'h0007, 1'b0, 1'b0);

        // rst and strt together: rst wins.
        @(negedge clk);
        rst  = 1'b1;
        strt = 1'b1;
        in   = 16'd5;
        @(negedge clk);
        rst  = 1'b0;
        strt = 1'b0;
        check("rst_wins_busy", b5_busy, 1'b0);

        // Randomized traffic with boundary-biased operands and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) == 0);
            strt = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0: in = 16'($urandom_range(0, 9));
                1: in = bnd[$urandom_range(0, 7)];
                default: in = 16'($urandom);
            endcase
        end
        @(negedge clk);
        rst  = 1'b0;
        strt = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
